// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module : sync_fifo_pkg
// Brief  : Shared types and helpers for the parametrised synchronous FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Threshold legality: almost_full in 1..DEPTH, almost_empty in 0..DEPTH-1.
    function automatic bit levels_legal(input int depth, input int af, input int ae);
        return (depth >= 2) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// ============================================================================
// Module : sync_fifo_ram
// Brief  : DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module : sync_fifo_param
// Brief  : Parametrised synchronous FIFO with fill count, thresholds, sticky
//          error flags and selectable standard / first-word-fall-through read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_en,
    input  logic                          r_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int               c_cw   = count_width(DEPTH);
    localparam int               c_aw   = $clog2(DEPTH);
    localparam logic [c_aw-1:0]  c_last = c_aw'(DEPTH - 1);
    localparam logic [c_cw-1:0]  c_full = c_cw'(DEPTH);
    localparam logic [c_cw-1:0]  c_af   = c_cw'(AF_LEVEL);
    localparam logic [c_cw-1:0]  c_ae   = c_cw'(AE_LEVEL);
    localparam fifo_mode_e       c_mode = (FWFT != 0) ? MODE_FWFT : MODE_STD;

    generate
        if (!levels_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
            $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_cw-1:0]       r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [c_cw-1:0]       w_count_next;
    logic [DATA_WIDTH-1:0] w_rdata;

    // A write into a full FIFO is still taken when a read frees the slot.
    assign w_wr_ok      = w_en && (!r_full || r_en);
    assign w_rd_ok      = r_en && !r_empty;
    assign w_count_next = r_count + c_cw'(w_wr_ok) - c_cw'(w_rd_ok);

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (c_aw)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_ok),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count        <= w_count_next;
            r_full         <= (w_count_next == c_full);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= c_af);
            r_almost_empty <= (w_count_next <= c_ae);
            // Set has priority over clear.
            r_overflow     <= (w_en && r_full && !r_en) || (r_overflow && !clr_err);
            r_underflow    <= (r_en && r_empty) || (r_underflow && !clr_err);
        end
    end

    generate
        if (c_mode == MODE_FWFT) begin : g_fwft
            // Head word is presented directly; zero while empty keeps reset value clean.
            assign data_out = r_empty ? '0 : w_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_ok) begin
                    r_data_out <= w_rdata;
                end
            end
            assign data_out = r_data_out;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module : tb_sync_fifo_param
// Brief  : Directed self-checking bench: a standard-read 16-deep FIFO and a
//          first-word-fall-through 5-deep FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DEPTH=16, AF=14, AE=2, standard read
    logic       rst0 = 1'b1, w_en0 = 1'b0, r_en0 = 1'b0, clr0 = 1'b0;
    logic [7:0] din0 = '0, dout0;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic [4:0] count0;

    // Instance 1: DEPTH=5, AF=3, AE=2, FWFT
    logic       rst1 = 1'b1, w_en1 = 1'b0, r_en1 = 1'b0, clr1 = 1'b0;
    logic [7:0] din1 = '0, dout1;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [2:0] count1;

    int total = 0;
    int bad   = 0;

    sync_fifo_param #(
        .DATA_WIDTH (8), .DEPTH (16), .AF_LEVEL (14), .AE_LEVEL (2), .FWFT (0)
    ) dut0 (
        .clk (clk), .rst (rst0), .w_en (w_en0), .r_en (r_en0), .data_in (din0),
        .clr_err (clr0), .data_out (dout0), .full (full0), .empty (empty0),
        .almost_full (af0), .almost_empty (ae0), .count (count0),
        .overflow (ovf0), .underflow (unf0)
    );

    sync_fifo_param #(
        .DATA_WIDTH (8), .DEPTH (5), .AF_LEVEL (3), .AE_LEVEL (2), .FWFT (1)
    ) dut1 (
        .clk (clk), .rst (rst1), .w_en (w_en1), .r_en (r_en1), .data_in (din1),
        .clr_err (clr1), .data_out (dout1), .full (full1), .empty (empty1),
        .almost_full (af1), .almost_empty (ae1), .count (count1),
        .overflow (ovf1), .underflow (unf1)
    );

    // One clock of stimulus on instance 0; returns 1 time unit after the edge.
    task automatic op0(input logic we, input logic re, input logic [7:0] d, input logic clr);
        w_en0 = we; r_en0 = re; din0 = d; clr0 = clr;
        @(posedge clk); #1;
        w_en0 = 1'b0; r_en0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic op1(input logic we, input logic re, input logic [7:0] d);
        w_en1 = we; r_en1 = re; din1 = d;
        @(posedge clk); #1;
        w_en1 = 1'b0; r_en1 = 1'b0;
    endtask

    // status vector order: {full, empty, almost_full, almost_empty, overflow, underflow}
    task automatic test_reset;
        rst0 = 1'b1;
        op0(1'b0, 1'b0, 8'h00, 1'b0);
        op0(1'b0, 1'b0, 8'h00, 1'b0);
        rst0 = 1'b0;
        total++;
        if ({full0, empty0, af0, ae0, ovf0, unf0} !== 6'b010100) begin
            bad++; $display("FAIL reset_flags got=%b exp=%b", {full0, empty0, af0, ae0, ovf0, unf0}, 6'b010100);
        end
        total++;
        if (count0 !== 5'd0 || dout0 !== 8'h00) begin
            bad++; $display("FAIL reset_count_data got count=%0d data=%h exp count=0 data=00", count0, dout0);
        end
    endtask

    task automatic test_fill;
        logic [5:0] exp;
        for (int i = 1; i <= 16; i++) begin
            op0(1'b1, 1'b0, 8'(i), 1'b0);
            exp = {(i == 16), 1'b0, (i >= 14), (i <= 2), 1'b0, 1'b0};
            total++;
            if (count0 !== 5'(i) || {full0, empty0, af0, ae0, ovf0, unf0} !== exp) begin
                bad++; $display("FAIL fill_%0d got count=%0d flags=%b exp count=%0d flags=%b",
                                i, count0, {full0, empty0, af0, ae0, ovf0, unf0}, i, exp);
            end
        end
    endtask

    task automatic test_overflow;
        op0(1'b1, 1'b0, 8'hAA, 1'b0);
        total++;
        if (ovf0 !== 1'b1 || count0 !== 5'd16 || full0 !== 1'b1) begin
            bad++; $display("FAIL overflow_set got ovf=%b count=%0d full=%b exp ovf=1 count=16 full=1", ovf0, count0, full0);
        end
        op0(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (ovf0 !== 1'b1) begin
            bad++; $display("FAIL overflow_sticky got=%b exp=1", ovf0);
        end
        op0(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (ovf0 !== 1'b0 || count0 !== 5'd16) begin
            bad++; $display("FAIL overflow_clear got ovf=%b count=%0d exp ovf=0 count=16", ovf0, count0);
        end
    endtask

    task automatic test_drain_underflow;
        logic [5:0] exp;
        for (int i = 1; i <= 16; i++) begin
            op0(1'b0, 1'b1, 8'h00, 1'b0);
            exp = {1'b0, (i == 16), ((16 - i) >= 14), ((16 - i) <= 2), 1'b0, 1'b0};
            total++;
            if (dout0 !== 8'(i) || count0 !== 5'(16 - i) || {full0, empty0, af0, ae0, ovf0, unf0} !== exp) begin
                bad++; $display("FAIL drain_%0d got data=%h count=%0d flags=%b exp data=%h count=%0d flags=%b",
                                i, dout0, count0, {full0, empty0, af0, ae0, ovf0, unf0}, 8'(i), 16 - i, exp);
            end
        end
        op0(1'b0, 1'b1, 8'h00, 1'b0);
        total++;
        if (unf0 !== 1'b1 || count0 !== 5'd0 || dout0 !== 8'h10) begin
            bad++; $display("FAIL underflow_set got unf=%b count=%0d data=%h exp unf=1 count=0 data=10", unf0, count0, dout0);
        end
        op0(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (unf0 !== 1'b0) begin
            bad++; $display("FAIL underflow_clear got=%b exp=0", unf0);
        end
    endtask

    task automatic test_wrap;
        int errs;
        errs = 0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 10; k++) op0(1'b1, 1'b0, 8'(8'h20 + b * 10 + k), 1'b0);
            for (int k = 0; k < 10; k++) begin
                op0(1'b0, 1'b1, 8'h00, 1'b0);
                if (dout0 !== 8'(8'h20 + b * 10 + k)) begin
                    errs++;
                    $display("FAIL wrap_word_%0d got=%h exp=%h", b * 10 + k, dout0, 8'(8'h20 + b * 10 + k));
                end
            end
        end
        total++;
        if (errs != 0 || empty0 !== 1'b1) begin
            bad++; $display("FAIL wrap_stream got errors=%0d empty=%b exp errors=0 empty=1", errs, empty0);
        end
    endtask

    task automatic test_simultaneous;
        int errs;
        errs = 0;
        for (int i = 0; i < 16; i++) op0(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        op0(1'b1, 1'b1, 8'h55, 1'b0);
        total++;
        if (count0 !== 5'd16 || full0 !== 1'b1 || dout0 !== 8'h60 || ovf0 !== 1'b0) begin
            bad++; $display("FAIL simul_full got count=%0d full=%b data=%h ovf=%b exp count=16 full=1 data=60 ovf=0",
                            count0, full0, dout0, ovf0);
        end
        for (int i = 1; i <= 16; i++) begin
            op0(1'b0, 1'b1, 8'h00, 1'b0);
            if (dout0 !== ((i == 16) ? 8'h55 : 8'(8'h60 + i))) begin
                errs++;
                $display("FAIL simul_drain_%0d got=%h exp=%h", i, dout0, (i == 16) ? 8'h55 : 8'(8'h60 + i));
            end
        end
        total++;
        if (errs != 0 || empty0 !== 1'b1) begin
            bad++; $display("FAIL simul_order got errors=%0d empty=%b exp errors=0 empty=1", errs, empty0);
        end
        op0(1'b1, 1'b1, 8'h77, 1'b0);
        total++;
        if (count0 !== 5'd1 || unf0 !== 1'b1 || empty0 !== 1'b0) begin
            bad++; $display("FAIL simul_empty got count=%0d unf=%b empty=%b exp count=1 unf=1 empty=0", count0, unf0, empty0);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 6; i++) op0(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        total++;
        if (count0 !== 5'd7 || unf0 !== 1'b1) begin
            bad++; $display("FAIL pre_reset got count=%0d unf=%b exp count=7 unf=1", count0, unf0);
        end
        rst0 = 1'b1;
        op0(1'b1, 1'b1, 8'hEE, 1'b0);
        rst0 = 1'b0;
        total++;
        if (count0 !== 5'd0 || {full0, empty0, af0, ae0, ovf0, unf0} !== 6'b010100 || dout0 !== 8'h00) begin
            bad++; $display("FAIL mid_reset got count=%0d flags=%b data=%h exp count=0 flags=010100 data=00",
                            count0, {full0, empty0, af0, ae0, ovf0, unf0}, dout0);
        end
        op0(1'b1, 1'b0, 8'h99, 1'b0);
        op0(1'b0, 1'b1, 8'h00, 1'b0);
        total++;
        if (dout0 !== 8'h99 || count0 !== 5'd0 || empty0 !== 1'b1) begin
            bad++; $display("FAIL post_reset got data=%h count=%0d empty=%b exp data=99 count=0 empty=1", dout0, count0, empty0);
        end
    endtask

    task automatic test_fwft;
        int errs;
        int n;
        rst1 = 1'b1;
        op1(1'b0, 1'b0, 8'h00);
        rst1 = 1'b0;
        total++;
        if (empty1 !== 1'b1 || count1 !== 3'd0 || dout1 !== 8'h00) begin
            bad++; $display("FAIL fwft_reset got empty=%b count=%0d data=%h exp empty=1 count=0 data=00", empty1, count1, dout1);
        end
        op1(1'b1, 1'b0, 8'h3C);
        total++;
        if (empty1 !== 1'b0 || dout1 !== 8'h3C || count1 !== 3'd1) begin
            bad++; $display("FAIL fwft_fallthrough got empty=%b data=%h count=%0d exp empty=0 data=3c count=1", empty1, dout1, count1);
        end
        op1(1'b0, 1'b1, 8'h00);
        total++;
        if (empty1 !== 1'b1 || count1 !== 3'd0) begin
            bad++; $display("FAIL fwft_pop got empty=%b count=%0d exp empty=1 count=0", empty1, count1);
        end
        errs = 0;
        n = 0;
        for (int b = 0; b < 3; b++) begin
            int len;
            len = (b == 2) ? 2 : 5;
            for (int k = 0; k < len; k++) op1(1'b1, 1'b0, 8'(8'hC0 + n + k));
            if (b == 0) begin
                total++;
                if (full1 !== 1'b1 || af1 !== 1'b1 || count1 !== 3'd5) begin
                    bad++; $display("FAIL fwft_full got full=%b af=%b count=%0d exp full=1 af=1 count=5", full1, af1, count1);
                end
            end
            for (int k = 0; k < len; k++) begin
                if (dout1 !== 8'(8'hC0 + n) || empty1 !== 1'b0) begin
                    errs++;
                    $display("FAIL fwft_word_%0d got data=%h empty=%b exp data=%h empty=0", n, dout1, empty1, 8'(8'hC0 + n));
                end
                op1(1'b0, 1'b1, 8'h00);
                n++;
            end
        end
        total++;
        if (errs != 0 || empty1 !== 1'b1 || unf1 !== 1'b0 || ovf1 !== 1'b0) begin
            bad++; $display("FAIL fwft_stream got errors=%0d empty=%b unf=%b ovf=%b exp errors=0 empty=1 unf=0 ovf=0",
                            errs, empty1, unf1, ovf1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_fwft();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised successor of the team's 8-bit synchronous FIFO: configurable data width and depth, selectable read mode (standard registered read or first-word-fall-through).
- Adds fill-level count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Sits between a single-clock producer and consumer; drop-in for existing FIFO benches when DATA_WIDTH=8.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
DEPTH, 16, number of entries; any integer >= 2, not restricted to powers of two
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
w_en  input  1  write request
r_en  input  1  read request
data_in  input  DATA_WIDTH  write data
clr_err  input  1  clears overflow/underflow sticky flags
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at clock edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0. Memory contents are not reset. Reset overrides every other input in that cycle, including mid-burst.
- Accept rules, evaluated on registered state at the edge:
  - wr_ok = w_en && (!full || r_en).
  - rd_ok = r_en && !empty.
- Full with w_en && r_en: both accepted, count unchanged, written word goes to the freed slot.
- Empty with w_en && r_en: write accepted, read rejected, underflow set.
- Pointers increment on accept and wrap from DEPTH-1 to 0; no power-of-two assumption.
- count_next = count + wr_ok - rd_ok. All flags are registered and computed from count_next, so they change in the same cycle as count. No combinational path from inputs to flags.
- Error flags:
  - overflow sets when w_en && full && !r_en.
  - underflow sets when r_en && empty.
  - Both hold until rst or clr_err. If set and clear coincide, set wins.
  - Rejected operations do not modify pointers or memory.
- FWFT=0: on rd_ok, data_out is loaded with mem[rd_ptr] at that edge (visible the cycle after r_en). Otherwise data_out holds its last value.
- FWFT=1:
  - data_out = mem[rd_ptr], valid whenever empty=0; r_en pops.
  - A word written into an empty FIFO appears on data_out the cycle after its write.
  - When empty=1, data_out is don't-care; the bench must not check it.
- Ordering is strictly first-in first-out. Data integrity holds across pointer wrap.

Decomposition:
- Package sync_fifo_pkg:
  - function for count width, equal to $clog2(DEPTH+1).
  - fifo_mode_e enum (STD, FWFT).
  - parameter legality check macro/function for AF_LEVEL/AE_LEVEL ranges.
- Sub-module sync_fifo_ram: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read port.
- Top level holds pointers, count, flag registers and the read-mode output stage.

Test Plan:
- Reset/fill (DEPTH=16, AF=14, AE=2, FWFT=0):
  - rst then 16 writes 0x01..0x10 -> count 0..16, almost_empty deasserts when count=3, almost_full asserts when count=14, full at 16, overflow=0.
- Overflow and clear:
  - Full FIFO, w_en=1, r_en=0, data 0xAA -> overflow=1, count stays 16, 0xAA never read out.
  - clr_err=1 -> overflow=0 next cycle.
- Drain, underflow and wrap:
  - 16 reads -> data_out 0x01..0x10 in order, one cycle after each r_en, empty at end.
  - 17th read -> underflow=1.
  - Write/read 40 more words -> in-order data across pointer wrap.
- Simultaneous operations:
  - Full FIFO, w_en=r_en=1, data 0x55 -> count stays 16, oldest word emitted, 0x55 emerges last.
  - Empty FIFO, w_en=r_en=1 -> count=1, underflow=1.
- FWFT=1, DEPTH=5 (non-power-of-two):
  - Write 0x3C into empty -> data_out=0x3C next cycle with no r_en.
  - r_en -> empty=1.
  - 12-word stream -> correct order through wrap at index 4.
- Reset mid-operation:
  - count=7, assert rst with w_en=r_en=1 -> next cycle count=0, empty=1, flags cleared.
  - Subsequent write/read returns the new data only.
